// File: rtl/tff_pkg.sv
// ----------------------------------------------------------------------------
// tff_pkg
// Shared types and constants for the toggle-event decoder.
//   tff_dec_state_t : decoder FSM states (INIT while the synchroniser settles,
//                     RUN while edges are being turned into events)
//   *_DEFAULT       : default parameter values for the decoder
//   InitCntW        : width of the INIT cycle counter (counts 0..SYNC_STAGES,
//                     SYNC_STAGES being at most 4)
// ----------------------------------------------------------------------------
package tff_pkg;

  typedef enum logic [0:0] {
    INIT,
    RUN
  } tff_dec_state_t;

  localparam int unsigned SYNC_STAGES_DEFAULT = 2;
  localparam int unsigned CNT_W_DEFAULT       = 4;
  localparam int unsigned SEQ_W_DEFAULT       = 8;

  localparam int unsigned InitCntW = 3;

endpackage

// File: rtl/tff_toggle_decoder_if.sv
// ----------------------------------------------------------------------------
// tff_toggle_decoder_if
// Event token handshake between the toggle decoder (master) and its consumer
// (slave).
//   ev_valid : at least one event pending          (master -> slave)
//   ev_ready : consumer accepts the head event     (slave  -> master)
//   ev_seq   : sequence number of the head event   (master -> slave)
//   pending  : number of buffered events           (master -> slave)
//   overflow : sticky, an event was dropped        (master -> slave)
//   clr_ovf  : clears overflow                     (slave  -> master)
// ----------------------------------------------------------------------------
interface tff_toggle_decoder_if
  import tff_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT,
  parameter int unsigned SEQ_W = SEQ_W_DEFAULT
) ();

  logic             ev_valid;
  logic             ev_ready;
  logic [SEQ_W-1:0] ev_seq;
  logic [CNT_W-1:0] pending;
  logic             overflow;
  logic             clr_ovf;

  modport master (
    output ev_valid,
    output ev_seq,
    output pending,
    output overflow,
    input  ev_ready,
    input  clr_ovf
  );

  modport slave (
    input  ev_valid,
    input  ev_seq,
    input  pending,
    input  overflow,
    output ev_ready,
    output clr_ovf
  );

endinterface

// File: rtl/tff_sync.sv
// ----------------------------------------------------------------------------
// tff_sync
// Flop-chain synchroniser bringing the asynchronous toggle line into i_clk.
//   i_clk : clock
//   i_rst : synchronous active-high reset, clears every stage to 0
//   i_d   : asynchronous input level
//   o_q   : synchronised level (last stage)
// ----------------------------------------------------------------------------
module tff_sync
  import tff_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/tff_toggle_decoder.sv
// ----------------------------------------------------------------------------
// tff_toggle_decoder
// Turns a toggle-encoded event line (every level change is one event) into
// handshaked event tokens with a wrapping sequence number.
//   i_clk  : clock, all state on posedge
//   i_rst  : synchronous active-high reset
//   i_t    : toggle-encoded event line, asynchronous to i_clk
//   o_q    : synchronised level of i_t
//   ev_if  : event handshake (valid/ready, head sequence number, pending
//            count, sticky overflow and its clear)
// ----------------------------------------------------------------------------
module tff_toggle_decoder
  import tff_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int unsigned CNT_W       = CNT_W_DEFAULT,
  parameter int unsigned SEQ_W       = SEQ_W_DEFAULT
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_t,
  output logic                        o_q,
  tff_toggle_decoder_if.master        ev_if
);

  localparam logic [CNT_W-1:0]    PendMax  = '1;
  localparam logic [InitCntW-1:0] InitLast = InitCntW'(SYNC_STAGES);

  tff_dec_state_t      r_state;
  tff_dec_state_t      w_state_nxt;
  logic [InitCntW-1:0] r_init_cnt;
  logic [InitCntW-1:0] w_init_cnt_nxt;

  logic                w_q;
  logic                r_prev;
  logic                w_detect;
  logic                w_accept;
  logic                w_drop;

  logic [CNT_W-1:0]    r_pending;
  logic [CNT_W-1:0]    w_pending_nxt;
  logic [SEQ_W-1:0]    r_seq;
  logic [SEQ_W-1:0]    w_seq_nxt;
  logic                r_ovf;
  logic                w_ovf_nxt;

  tff_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_t),
    .o_q   (w_q)
  );

  // INIT lets the synchroniser and r_prev settle on the current line level so
  // a line already high at reset release is not mistaken for an event.
  always_comb begin
    w_state_nxt    = r_state;
    w_init_cnt_nxt = r_init_cnt;
    w_detect       = 1'b0;
    unique case (r_state)
      INIT: begin
        if (r_init_cnt == InitLast) begin
          w_state_nxt    = RUN;
          w_init_cnt_nxt = '0;
        end else begin
          w_init_cnt_nxt = r_init_cnt + InitCntW'(1);
        end
      end
      RUN: begin
        w_detect = w_q ^ r_prev;
      end
      default: begin
        w_state_nxt    = INIT;
        w_init_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= INIT;
      r_init_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_cnt_nxt;
    end
  end

  // Event buffer. A detect and an accept in the same cycle cancel out, which
  // is also what keeps a full buffer from dropping while it is being drained.
  always_comb begin
    w_pending_nxt = r_pending;
    w_seq_nxt     = r_seq;
    w_ovf_nxt     = r_ovf;
    w_accept      = (r_pending != '0) && ev_if.ev_ready;
    w_drop        = w_detect && !w_accept && (r_pending == PendMax);

    if (w_detect && !w_accept && !w_drop) begin
      w_pending_nxt = r_pending + CNT_W'(1);
    end else if (w_accept && !w_detect) begin
      w_pending_nxt = r_pending - CNT_W'(1);
    end

    if (w_accept) begin
      w_seq_nxt = r_seq + SEQ_W'(1);
    end

    // A drop wins over a clear in the same cycle.
    if (w_drop) begin
      w_ovf_nxt = 1'b1;
    end else if (ev_if.clr_ovf) begin
      w_ovf_nxt = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev    <= 1'b0;
      r_pending <= '0;
      r_seq     <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_prev    <= w_q;
      r_pending <= w_pending_nxt;
      r_seq     <= w_seq_nxt;
      r_ovf     <= w_ovf_nxt;
    end
  end

  assign o_q            = w_q;
  assign ev_if.ev_valid = (r_pending != '0);
  assign ev_if.ev_seq   = r_seq;
  assign ev_if.pending  = r_pending;
  assign ev_if.overflow = r_ovf;

endmodule

// File: tb/tb_tff_toggle_decoder.sv
module tb_tff_toggle_decoder;
  import tff_pkg::*;

  localparam int unsigned S  = 2;
  localparam int unsigned CW = 4;
  localparam int unsigned SW = 8;
  localparam int          PMAX = (1 << CW) - 1;
  localparam int          SMOD = 1 << SW;

  logic clk = 1'b0;
  logic rst;
  logic t;
  logic q;

  tff_toggle_decoder_if #(.CNT_W(CW), .SEQ_W(SW)) ev_if ();

  tff_toggle_decoder #(
    .SYNC_STAGES (S),
    .CNT_W       (CW),
    .SEQ_W       (SW)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_t   (t),
    .o_q   (q),
    .ev_if (ev_if.master)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic t;
    logic rdy;
    logic clr;
    logic exp_q;
    logic exp_valid;
    int   exp_pend;
    int   exp_seq;
    logic exp_ovf;
  } vec_t;

  vec_t tbl[13];
  logic cur_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_state(input string name, input logic v, input int p, input int s,
                             input logic o);
    check({name, " valid"}, ev_if.ev_valid, v);
    check({name, " pending"}, ev_if.pending, p);
    check({name, " seq"}, ev_if.ev_seq, s);
    check({name, " overflow"}, ev_if.overflow, o);
  endtask

  // Drive inputs at the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic ti, input logic rdy, input logic clr);
    @(negedge clk);
    t              = ti;
    ev_if.ev_ready = rdy;
    ev_if.clr_ovf  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic lvl);
    rst = 1'b1;
    step(lvl, 1'b0, 1'b0);
    step(lvl, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < S + 3; i++) step(lvl, 1'b0, 1'b0);
  endtask

  // Toggle the line once and hold it for 'hold' cycles.
  task automatic toggle(input int hold, input logic rdy);
    cur_t = ~cur_t;
    for (int i = 0; i < hold; i++) step(cur_t, rdy, 1'b0);
  endtask

  task automatic settle(input logic rdy);
    for (int i = 0; i < S + 2; i++) step(cur_t, rdy, 1'b0);
  endtask

  initial begin
    logic hist[$];
    int   m_pend, m_seq, hold, prev_seq;
    logic m_ovf, det, acc, drop, rdy, clr, wrapped;

    rst            = 1'b1;
    t              = 1'b0;
    ev_if.ev_ready = 1'b0;
    ev_if.clr_ovf  = 1'b0;

    //            t     rdy   clr   q     valid pend seq ovf
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1, 0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1, 1, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 2, 1'b0};

    // Reset with the line held high: nothing must come out of INIT.
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("reset q", q, 1'b0);
    check_state("reset", 1'b0, 0, 0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].t, tbl[i].rdy, tbl[i].clr);
      check($sformatf("tbl[%0d] q", i), q, tbl[i].exp_q);
      check_state($sformatf("tbl[%0d]", i), tbl[i].exp_valid, tbl[i].exp_pend,
                  tbl[i].exp_seq, tbl[i].exp_ovf);
    end
    cur_t = 1'b1;

    // Five buffered events, then drained in order.
    do_reset(cur_t);
    for (int i = 0; i < 5; i++) toggle(3, 1'b0);
    settle(1'b0);
    check_state("buf5", 1'b1, 5, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("drain seq %0d", i), ev_if.ev_seq, i);
      step(cur_t, 1'b1, 1'b0);
    end
    check_state("drained", 1'b0, 0, 5, 1'b0);

    // Fill to capacity, overflow, set-over-clear priority, then clear.
    do_reset(cur_t);
    for (int i = 0; i < PMAX + 1; i++) toggle(3, 1'b0);
    settle(1'b0);
    check_state("full", 1'b1, PMAX, 0, 1'b1);
    cur_t = ~cur_t;
    step(cur_t, 1'b0, 1'b0);
    step(cur_t, 1'b0, 1'b0);
    step(cur_t, 1'b0, 1'b1);
    check_state("drop+clr", 1'b1, PMAX, 0, 1'b1);
    step(cur_t, 1'b0, 1'b1);
    check_state("clr", 1'b1, PMAX, 0, 1'b0);

    // Detect coinciding with accept, then a long run wrapping ev_seq.
    do_reset(cur_t);
    for (int i = 0; i < 3; i++) toggle(3, 1'b0);
    settle(1'b0);
    check_state("pend3", 1'b1, 3, 0, 1'b0);
    cur_t = ~cur_t;
    step(cur_t, 1'b0, 1'b0);
    step(cur_t, 1'b0, 1'b0);
    step(cur_t, 1'b1, 1'b0);
    check_state("coincide", 1'b1, 3, 1, 1'b0);
    for (int i = 0; i < 3; i++) step(cur_t, 1'b1, 1'b0);
    check_state("pre-wrap", 1'b0, 0, 4, 1'b0);
    wrapped = 1'b0;
    for (int i = 0; i < 300; i++) begin
      cur_t = ~cur_t;
      for (int j = 0; j < 2; j++) begin
        prev_seq = int'(ev_if.ev_seq);
        step(cur_t, 1'b1, 1'b0);
        if (prev_seq == SMOD - 1 && ev_if.ev_seq == '0) wrapped = 1'b1;
      end
    end
    settle(1'b1);
    check("seq wrapped", wrapped, 1'b1);
    check_state("post-wrap", 1'b0, 0, (4 + 300) % SMOD, 1'b0);

    // Reset in the middle of operation.
    for (int i = 0; i < 7; i++) toggle(3, 1'b0);
    settle(1'b0);
    check_state("pend7", 1'b1, 7, 300 % SMOD + 4 - 300 % SMOD + 300 % SMOD, 1'b0);
    rst = 1'b1;
    step(cur_t, 1'b0, 1'b0);
    rst = 1'b0;
    check_state("mid-reset", 1'b0, 0, 0, 1'b0);
    check("mid-reset state", dut.r_state, INIT);

    // Randomised traffic against a model built from the sampled line levels.
    do_reset(cur_t);
    hist.delete();
    for (int i = 0; i < S + 2; i++) hist.push_front(cur_t);
    m_pend = 0;
    m_seq  = 0;
    m_ovf  = 1'b0;
    hold   = 0;
    for (int c = 0; c < 800; c++) begin
      if (hold == 0) begin
        cur_t = ~cur_t;
        hold  = $urandom_range(2, 5);
      end
      hold--;
      rdy = (c < 400) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);

      // An event reaches the buffer S edges after the changed level is sampled.
      hist.push_front(cur_t);
      void'(hist.pop_back());
      det  = (hist[S] != hist[S+1]);
      acc  = (m_pend != 0) && rdy;
      drop = det && !acc && (m_pend == PMAX);
      if (det && !acc && !drop) m_pend++;
      else if (acc && !det)     m_pend--;
      if (acc) m_seq = (m_seq + 1) % SMOD;
      if (drop)     m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;

      step(cur_t, rdy, clr);
      check($sformatf("rnd[%0d] q", c), q, hist[S-1]);
      check_state($sformatf("rnd[%0d]", c), (m_pend != 0), m_pend, m_seq, m_ovf);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/tff_toggle_decoder.md
# tff_toggle_decoder

Receive-side companion to the team's T flip-flop: converts a toggle-encoded event line (each level change = one event) back into discrete, handshaked event tokens. The raw toggle line is synchronised into `clk`, level changes are detected, and events are buffered in a pending counter and presented on a valid/ready interface with a wrapping sequence number. It sits at the consumer end of any link where a producer signals events by toggling a flip-flop output.

## Interface
- `SYNC_STAGES`, 2: synchroniser depth on `T`; legal range 2–4.
- `CNT_W`, 4: pending-event counter width; capacity 2^CNT_W−1 events.
- `SEQ_W`, 8: event sequence-number width.

- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: reset, synchronous, active-high.
- `T` in 1: toggle-encoded event line, asynchronous to `clk`.
- `Q` out 1: synchronised level of `T` (last synchroniser stage).
- `ev_valid` out 1: at least one event pending.
- `ev_ready` in 1: consumer accepts head event.
- `ev_seq` out SEQ_W: sequence number of head event.
- `pending` out CNT_W: number of buffered events.
- `overflow` out 1: sticky; an event was dropped.
- `clr_ovf` in 1: clears `overflow`.

## Operation
- Reset values: `Q`=0, `ev_valid`=0, `ev_seq`=0, `pending`=0, `overflow`=0; synchroniser and previous-level register 0; FSM in INIT.
- FSM states:
  - INIT: runs SYNC_STAGES+1 cycles after reset. Previous-level register tracks synchroniser output; no events detected. Moves to RUN when the cycle count expires. Prevents a spurious event when `T`=1 at reset release.
  - RUN: `detect = Q ^ prev`; `prev <= Q` every cycle.
- Handshake: `accept = ev_valid & ev_ready`. `ev_valid = (pending != 0)`, driven from registered state only.
- Pending counter:
  - `detect` & !`accept` → +1.
  - `accept` & !`detect` → −1.
  - Both or neither → unchanged.
- Full: `detect` with `pending` = 2^CNT_W−1 and no `accept` → event dropped, `pending` holds, `overflow` set.
- `ev_seq` increments by 1 on each `accept`, modulo 2^SEQ_W. It is not incremented by dropped events.
- `overflow` set has priority over `clr_ovf` in the same cycle.
- `ev_ready` while `ev_valid`=0 has no effect.
- `rst` mid-operation discards all pending events and returns to INIT; `ev_seq` returns to 0.

## Timing
- Latency: `T` level change settling before edge k gives `Q` updated after edge k+SYNC_STAGES−1 and `ev_valid`/`pending` updated after edge k+SYNC_STAGES. With the default depth, `ev_valid` is high 2 cycles after the toggle is sampled.
- One accept per cycle maximum; sustained throughput is 1 event/cycle.
- Sender requirement: each `T` level is held ≥ 2 `clk` cycles. Faster toggling may merge or drop events; this is undefined and not checked.
- `ev_seq` and `ev_valid` are stable while `ev_valid`=1 and `ev_ready`=0, except that `pending` may increase.

## Structure
- Package `tff_pkg` holds:
  - state enum `tff_dec_state_t` {INIT, RUN};
  - default values for SYNC_STAGES, CNT_W and SEQ_W;
  - the INIT cycle-count width constant.
- Sub-module `tff_sync`: parameterised SYNC_STAGES flop chain, reset to 0 by `rst`, output drives `Q`.
- Top level contains the FSM, edge detect, pending counter, sequence counter and overflow flag.

## Test plan
- Reset with `T`=1 held, then release → `ev_valid` stays 0 through INIT and after; `pending`=0, `Q`=1.
- From idle, toggle `T` 0→1 with `ev_ready`=1 → `ev_valid` pulses high for 1 cycle, 2 cycles after sampling, with `ev_seq`=0; `ev_seq`=1 afterwards.
- `ev_ready`=0, toggle `T` 5 times at 3-cycle spacing → `pending`=5. Then assert `ev_ready` for 5 cycles → `ev_seq` presented as 0..4, `pending`=0, `ev_valid`=0.
- CNT_W=4, `ev_ready`=0, 16 toggles → `pending`=15 and `overflow`=1. Assert `clr_ovf` in the same cycle as another drop → `overflow` stays 1; next cycle `clr_ovf` alone → 0.
- `pending`=3, a toggle detect coincides with an accept → `pending` stays 3 and `ev_seq` advances by 1. Run 300 accepted events → `ev_seq` wraps 255→0.
- Assert `rst` with `pending`=7 → next cycle `pending`=0, `ev_valid`=0, `ev_seq`=0, FSM in INIT.
